// File: rtl/accel_reader.sv
// Drains per-object accelerations from the engine read port into a valid/ready stream of {index, x, y}.
// Optional build macro ACCEL_READER_CHECKSUM_EN adds an XOR checksum output o_checksum.
module accel_reader #(
    parameter int m10k_address_len = 12,
    parameter int read_latency     = 2,
    parameter int fifo_depth       = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [m10k_address_len-1:0] i_num_objects,
    output logic [m10k_address_len-1:0] o_accel_addr,
    input  logic [31:0]                 i_x_accel,
    input  logic [31:0]                 i_y_accel,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [m10k_address_len-1:0] o_index,
    output logic [31:0]                 o_x,
    output logic [31:0]                 o_y,
    output logic                        o_last,
    output logic                        o_busy,
`ifdef ACCEL_READER_CHECKSUM_EN
    output logic [31:0]                 o_checksum,
`endif
    output logic                        o_done
);

    localparam int AW = m10k_address_len;
    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(fifo_depth);
    localparam logic [AW:0]   ONE_I = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW:0]   n_q;
    logic [AW:0]   icnt;
    logic [AW:0]   ecnt;
    logic [AW:0]   issue_addr;
    logic [AW-1:0] wcnt;
    logic [CW-1:0] credit;
    logic [CW-1:0] occ;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [read_latency:0] vld_p;
    logic          start_ok;
    logic          issue;
    logic          push;
    logic          pop;

    logic [AW-1:0] idx_mem [fifo_depth];
    logic [31:0]   x_mem   [fifo_depth];
    logic [31:0]   y_mem   [fifo_depth];

    assign start_ok   = (state == IDLE) && i_start;
    assign issue_addr = start_ok ? '0 : icnt;
    assign push       = vld_p[read_latency];
    assign o_valid    = (occ != '0);
    assign pop        = o_valid && i_ready;

    // Credit covers FIFO occupancy plus reads still in the latency pipe, so a push never finds the FIFO full.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (i_num_objects == '0) begin
                        state_nxt = FLUSH;
                    end else begin
                        issue     = 1'b1;
                        state_nxt = (i_num_objects == AW'(1)) ? FLUSH : RUN;
                    end
                end
            end
            RUN: begin
                if ((icnt < n_q) && ((credit < DEPTH) || pop)) begin
                    issue = 1'b1;
                    if (icnt == (n_q - ONE_I)) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if ((ecnt == n_q) || (pop && ((ecnt + ONE_I) == n_q))) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            n_q          <= '0;
            icnt         <= '0;
            ecnt         <= '0;
            wcnt         <= '0;
            credit       <= '0;
            occ          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            vld_p        <= '0;
            o_accel_addr <= '0;
        end else begin
            state <= state_nxt;
            vld_p <= {vld_p[read_latency-1:0], issue};
            if (issue) begin
                o_accel_addr <= issue_addr[AW-1:0];
                icnt         <= issue_addr + ONE_I;
            end
            if (issue && !pop)      credit <= credit + CW'(1);
            else if (!issue && pop) credit <= credit - CW'(1);
            if (push && !pop)       occ <= occ + CW'(1);
            else if (!push && pop)  occ <= occ - CW'(1);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                wcnt   <= wcnt + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                ecnt   <= ecnt + ONE_I;
            end
            if (start_ok) begin
                n_q  <= {1'b0, i_num_objects};
                ecnt <= '0;
                wcnt <= '0;
            end
        end
    end

    // Read data lands read_latency cycles after the address register changes.
    always_ff @(posedge i_clk) begin
        if (push) begin
            idx_mem[wr_ptr] <= wcnt;
            x_mem[wr_ptr]   <= i_x_accel;
            y_mem[wr_ptr]   <= i_y_accel;
        end
    end

    assign o_index = o_valid ? idx_mem[rd_ptr] : '0;
    assign o_x     = o_valid ? x_mem[rd_ptr]   : '0;
    assign o_y     = o_valid ? y_mem[rd_ptr]   : '0;
    assign o_last  = o_valid && (({1'b0, o_index} + ONE_I) == n_q);
    assign o_busy  = (state == RUN) || (state == FLUSH);
    assign o_done  = (state == DONE);

`ifdef ACCEL_READER_CHECKSUM_EN
    logic [31:0] chk;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            chk <= '0;
        end else if (start_ok) begin
            chk <= '0;
        end else if (pop) begin
            chk <= chk ^ o_x ^ o_y;
        end
    end

    assign o_checksum = chk;
`endif

endmodule
